// File: rtl/instr_class_encoder.sv
// Instruction-class encoder: classifies fetched words into a one-hot class code behind a 2-entry skid buffer.
// Optional macro DECODE_CHECK_EN adds funct3/funct7 legality checks to the illegal flag.
module instr_class_encoder #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  out_code,
  output logic [31:0] out_instr,
  output logic        out_illegal
);

  logic [1:0]  r_count;
  logic [9:0]  r_code_head, r_code_skid;
  logic [31:0] r_instr_head, r_instr_skid;
  logic        r_ill_head, r_ill_skid;

  logic [9:0]  w_dec_code;
  logic        w_dec_ill;
  logic        w_bad;
  logic        w_push, w_pop;

`ifdef DECODE_CHECK_EN
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];
`endif

  always_comb begin
    w_dec_code = 10'b0;
    w_dec_ill  = 1'b0;
    w_bad      = 1'b0;
    case (in_instr[6:0])
      7'b1101111: w_dec_code = 10'b0000000001;
      7'b1100111: w_dec_code = 10'b0000000010;
      7'b0110111: w_dec_code = 10'b0000000100;
      7'b0010111: w_dec_code = 10'b0000001000;
      7'b1100011: w_dec_code = 10'b0000010000;
      7'b0110011: w_dec_code = 10'b0000100000;
      7'b0100011: w_dec_code = 10'b0001000000;
      7'b0010011: w_dec_code = 10'b0010000000;
      7'b0000011: w_dec_code = 10'b0100000000;
      7'b1110011: w_dec_code = 10'b1000000000;
      default:    w_bad      = 1'b1;
    endcase
`ifdef DECODE_CHECK_EN
    case (in_instr[6:0])
      7'b1100111: if (w_funct3 != 3'b000) w_bad = 1'b1;
      7'b1100011: if (w_funct3 == 3'b010 || w_funct3 == 3'b011) w_bad = 1'b1;
      7'b0000011: if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111) w_bad = 1'b1;
      7'b0100011: if (w_funct3 > 3'b010) w_bad = 1'b1;
      7'b0110011: begin
        if (w_funct7 != 7'b0000000 && w_funct7 != 7'b0100000) w_bad = 1'b1;
        if (w_funct7 == 7'b0100000 && w_funct3 != 3'b000 && w_funct3 != 3'b101) w_bad = 1'b1;
      end
      7'b0010011: begin
        if (w_funct3 == 3'b001 && w_funct7 != 7'b0000000) w_bad = 1'b1;
        if (w_funct3 == 3'b101 && w_funct7 != 7'b0000000 && w_funct7 != 7'b0100000) w_bad = 1'b1;
      end
      default: ;
    endcase
`endif
    if (in_instr[1:0] != 2'b11) w_bad = 1'b1;
    if (w_bad) begin
      w_dec_code = 10'b0;
      w_dec_ill  = 1'b1;
    end
  end

  // in_ready is forced low while reset is held so fetch never hands over a word that would be lost
  assign in_ready    = rst_n & (r_count < 2'(DEPTH));
  assign out_valid   = (r_count != 2'd0);
  assign out_code    = r_code_head;
  assign out_instr   = r_instr_head;
  assign out_illegal = r_ill_head;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= 2'd0;
      r_code_head  <= 10'b0;
      r_instr_head <= 32'b0;
      r_ill_head   <= 1'b0;
      r_code_skid  <= 10'b0;
      r_instr_skid <= 32'b0;
      r_ill_skid   <= 1'b0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_code_head  <= w_dec_code;
            r_instr_head <= in_instr;
            r_ill_head   <= w_dec_ill;
          end else begin
            r_code_skid  <= w_dec_code;
            r_instr_skid <= in_instr;
            r_ill_skid   <= w_dec_ill;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          // Head registers keep the popped entry when the buffer drains, so outputs hold
          if (r_count == 2'd2) begin
            r_code_head  <= r_code_skid;
            r_instr_head <= r_instr_skid;
            r_ill_head   <= r_ill_skid;
          end
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          r_code_head  <= w_dec_code;
          r_instr_head <= in_instr;
          r_ill_head   <= w_dec_ill;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_class_encoder.sv
// Directed self-checking bench for instr_class_encoder (expectations follow DECODE_CHECK_EN when defined).
module tb_instr_class_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [9:0]  out_code;
  logic [31:0] out_instr;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  instr_class_encoder dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_instr(out_instr), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [9:0] code, input logic [31:0] instr,
                            input logic ill);
    check_val({tag, ".valid"}, 32'(out_valid), 32'd1);
    check_val({tag, ".code"}, 32'(out_code), 32'(code));
    check_val({tag, ".instr"}, out_instr, instr);
    check_val({tag, ".ill"}, 32'(out_illegal), 32'(ill));
  endtask

  logic [31:0] seq_w [4] = '{32'h0000006F, 32'h000012B7, 32'h00000517, 32'hFE000EE3};
  logic [9:0]  seq_c [4] = '{10'b0000000001, 10'b0000000100, 10'b0000001000, 10'b0000010000};
  logic [31:0] bad_w [3] = '{32'h0000000B, 32'h0000000F, 32'h00000090};

  initial begin
    #2;
    check_val("rst.in_ready", 32'(in_ready), 32'd0);
    check_val("rst.out_valid", 32'(out_valid), 32'd0);
    check_val("rst.code", 32'(out_code), 32'd0);
    check_val("rst.instr", out_instr, 32'd0);
    check_val("rst.ill", 32'(out_illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_val("idle.in_ready", 32'(in_ready), 32'd1);

    // single ADDI, one-cycle latency
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00500093;
    step();
    in_valid = 1'b0;
    check_head("addi", 10'b0010000000, 32'h00500093, 1'b0);
    step();
    check_val("addi.drain", 32'(out_valid), 32'd0);

    // back-to-back stream
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_instr = seq_w[i];
      step();
      check_head($sformatf("b2b%0d", i), seq_c[i], seq_w[i], 1'b0);
    end
    in_valid = 1'b0;
    step();
    check_val("b2b.drain", 32'(out_valid), 32'd0);

    // fill under backpressure, third word held
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00208033;
    step();
    check_val("bp.ready1", 32'(in_ready), 32'd1);
    in_instr = 32'h00112023;
    step();
    check_val("bp.ready2", 32'(in_ready), 32'd0);
    in_instr = 32'h00002083;
    step();
    check_val("bp.hold_ready", 32'(in_ready), 32'd0);
    check_head("bp.head", 10'b0000100000, 32'h00208033, 1'b0);
    out_ready = 1'b1;
    step();
    check_head("bp.pop1", 10'b0001000000, 32'h00112023, 1'b0);
    check_val("bp.ready3", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check_head("bp.pop2", 10'b0100000000, 32'h00002083, 1'b0);
    step();
    check_val("bp.empty", 32'(out_valid), 32'd0);
    check_val("bp.hold_code", 32'(out_code), 32'h100);

    // illegal opcodes and low bits
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_instr = bad_w[i];
      step();
      check_head($sformatf("ill%0d", i), 10'b0, bad_w[i], 1'b1);
    end
    in_valid = 1'b0;
    step();

    // flush with simultaneous push
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00500093;
    step();
    step();
    check_val("fl.full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check_val("fl.valid", 32'(out_valid), 32'd0);
    check_val("fl.ready", 32'(in_ready), 32'd1);
    step();
    check_val("fl.still_empty", 32'(out_valid), 32'd0);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h0000006F;
    step();
    in_valid = 1'b0;
    check_val("ar.pre", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("ar.valid", 32'(out_valid), 32'd0);
    check_val("ar.instr", out_instr, 32'd0);
    check_val("ar.ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // funct-field dependent words
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h02000033;
    step();
`ifdef DECODE_CHECK_EN
    check_head("mul", 10'b0, 32'h02000033, 1'b1);
`else
    check_head("mul", 10'b0000100000, 32'h02000033, 1'b0);
`endif
    in_instr = 32'h00003083;
    step();
    in_valid = 1'b0;
`ifdef DECODE_CHECK_EN
    check_head("ld", 10'b0, 32'h00003083, 1'b1);
`else
    check_head("ld", 10'b0100000000, 32'h00003083, 1'b0);
`endif
    step();
    check_val("end.empty", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
